// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_OP           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_FQ_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus; master is the fetch stage, slave the memory.
interface fetch_stage_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Synchronous FIFO with flush and occupancy count; head word is read combinationally.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues credit-limited word fetches, queues returned words
// and presents {pc, instruction} to decode; redirects discard stale in-flight words.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = DEFAULT_FQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 halt,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instruction
);

  localparam int            CW         = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(FQ_DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW:0]   credit_used;
  logic          q_empty;
  logic          issue;
  logic          rsp_take;
  logic          rsp_keep;
  logic          xfer;
  fetch_word_t   q_wdata;
  fetch_word_t   q_rdata;
  logic          unused_q_full;
  logic [1:0]    unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  assign credit_used     = {1'b0, outstanding} + {1'b0, q_count};
  assign imem.req_valid  = !rst && !halt && !redirect_valid && (credit_used < CREDIT_MAX);
  assign imem.addr       = pc;
  assign issue           = imem.req_valid && imem.req_ready;

  assign rsp_take        = imem.rsp_valid && (outstanding != '0);
  assign rsp_keep        = rsp_take && !redirect_valid && (drop_cnt == '0);
  assign outstanding_next = outstanding + CW'(issue) - CW'(rsp_take);

  // With no drops pending every outstanding request follows the last redirect in
  // sequence, so the oldest one was issued at pc - 4*outstanding.
  assign q_wdata.pc      = pc - (32'(outstanding) << 2);
  assign q_wdata.instr   = imem.rsp_data;

  assign id_valid        = !q_empty && !redirect_valid;
  assign xfer            = id_valid && id_ready;
  assign id_pc           = q_rdata.pc;
  assign id_instruction  = id_valid ? q_rdata.instr : NOP_OP;

  fetch_fifo #(
    .WIDTH ($bits(fetch_word_t)),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (xfer),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (unused_q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc       <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= outstanding_next;
      end else begin
        if (issue) pc <= next_pc(pc);
        if (rsp_take && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  rsp_without_request: assert property (
    @(posedge clk) disable iff (rst) !(imem.rsp_valid && outstanding == '0)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model plus a program-stream reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instruction (id_instruction)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  int cfg_req_rdy_pct = 100;
  int cfg_lat_min     = 1;
  int cfg_lat_max     = 1;

  // memory model: requests in flight, answered in order
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  bit          pend_stale[$];
  int          last_due = 0;

  // program-stream model
  int          queued    = 0;
  logic [31:0] exp_pc    = RESET_PC;
  logic [31:0] exp_issue = RESET_PC;

  logic [31:0] issue_log[$];
  logic [31:0] xfer_log [$];

  logic        obs_req_valid, obs_id_valid;
  logic [31:0] obs_addr, obs_id_pc, obs_id_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic step();
    bit          pres, stale, exp_reqv, exp_idv;
    int          due;
    @(negedge clk);
    imem.req_ready = ($urandom_range(0, 99) < cfg_req_rdy_pct);
    pres = !rst && (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    imem.rsp_valid = pres;
    imem.rsp_data  = pres ? memf(pend_addr[0]) : $urandom;
    #1;
    obs_req_valid = imem.req_valid;
    obs_addr      = imem.addr;
    obs_id_valid  = id_valid;
    obs_id_pc     = id_pc;
    obs_id_instr  = id_instruction;
    exp_reqv = !rst && !halt && !redirect_valid && ((pend_addr.size() + queued) < FQ_DEPTH);
    exp_idv  = (queued > 0) && !redirect_valid;

    n_checks++;
    if (obs_req_valid !== exp_reqv) begin
      n_errors++;
      $display("FAIL req_valid @%0d: got %b expected %b", cyc, obs_req_valid, exp_reqv);
    end
    if (!rst) begin
      if (exp_reqv) begin
        n_checks++;
        if (obs_addr !== exp_issue) begin
          n_errors++;
          $display("FAIL imem_addr @%0d: got %h expected %h", cyc, obs_addr, exp_issue);
        end
      end
      n_checks++;
      if (obs_id_valid !== exp_idv) begin
        n_errors++;
        $display("FAIL id_valid @%0d: got %b expected %b", cyc, obs_id_valid, exp_idv);
      end
      if (exp_idv) begin
        n_checks++;
        if (obs_id_pc !== exp_pc) begin
          n_errors++;
          $display("FAIL id_pc @%0d: got %h expected %h", cyc, obs_id_pc, exp_pc);
        end
        n_checks++;
        if (obs_id_instr !== memf(exp_pc)) begin
          n_errors++;
          $display("FAIL id_instr @%0d: got %h expected %h", cyc, obs_id_instr, memf(exp_pc));
        end
      end else begin
        n_checks++;
        if (obs_id_instr !== NOP_OP) begin
          n_errors++;
          $display("FAIL idle_instr @%0d: got %h expected %h", cyc, obs_id_instr, NOP_OP);
        end
      end

      if (obs_id_valid && id_ready) xfer_log.push_back(obs_id_pc);
      if (obs_req_valid && imem.req_ready) issue_log.push_back(obs_addr);

      if (exp_idv && id_ready) begin
        queued--;
        exp_pc += 32'd4;
      end
      if (pres) begin
        stale = pend_stale[0] || redirect_valid;
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
        void'(pend_stale.pop_front());
        if (!stale) queued++;
      end
      if (exp_reqv && imem.req_ready) begin
        due = cyc + $urandom_range(cfg_lat_min, cfg_lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(exp_issue);
        pend_due.push_back(due);
        pend_stale.push_back(1'b0);
        exp_issue += 32'd4;
      end
      if (redirect_valid) begin
        queued = 0;
        foreach (pend_stale[k]) pend_stale[k] = 1'b1;
        exp_pc    = {redirect_pc[31:2], 2'b00};
        exp_issue = {redirect_pc[31:2], 2'b00};
      end
    end else begin
      pend_addr.delete();
      pend_due.delete();
      pend_stale.delete();
      last_due  = 0;
      queued    = 0;
      exp_pc    = RESET_PC;
      exp_issue = RESET_PC;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
    issue_log.delete();
    xfer_log.delete();
  endtask

  task automatic test_reset();
    cfg_req_rdy_pct = 100; cfg_lat_min = 1; cfg_lat_max = 1;
    id_ready = 1'b1;
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs_req_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_req_valid: got %b expected 0", obs_req_valid);
      end
    end
    rst = 1'b0;
    issue_log.delete(); xfer_log.delete();
    step();
    n_checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL reset_first_fetch: got v=%b a=%h expected v=1 a=%h", obs_req_valid, obs_addr, RESET_PC);
    end
    n_checks++;
    if (obs_id_valid !== 1'b0 || obs_id_instr !== NOP_OP) begin
      n_errors++;
      $display("FAIL reset_id: got v=%b i=%h expected v=0 i=%h", obs_id_valid, obs_id_instr, NOP_OP);
    end
  endtask

  task automatic test_sequential();
    cfg_req_rdy_pct = 100; cfg_lat_min = 1; cfg_lat_max = 1;
    do_reset(3);
    id_ready = 1'b1;
    for (int i = 0; i < 14; i++) step();
    n_checks++;
    if (issue_log.size() < 4) begin
      n_errors++;
      $display("FAIL seq_issue_count: got %0d expected >= 4", issue_log.size());
    end
    for (int i = 0; i < issue_log.size(); i++) begin
      n_checks++;
      if (issue_log[i] !== RESET_PC + 32'(4 * i)) begin
        n_errors++;
        $display("FAIL seq_issue_addr[%0d]: got %h expected %h", i, issue_log[i], RESET_PC + 32'(4 * i));
      end
    end
    n_checks++;
    if (xfer_log.size() < 3) begin
      n_errors++;
      $display("FAIL seq_xfer_count: got %0d expected >= 3", xfer_log.size());
    end
    for (int i = 0; i < xfer_log.size(); i++) begin
      n_checks++;
      if (xfer_log[i] !== RESET_PC + 32'(4 * i)) begin
        n_errors++;
        $display("FAIL seq_id_pc[%0d]: got %h expected %h", i, xfer_log[i], RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    cfg_req_rdy_pct = 100; cfg_lat_min = 1; cfg_lat_max = 1;
    do_reset(2);
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (issue_log.size() != FQ_DEPTH) begin
      n_errors++;
      $display("FAIL bp_issue_count: got %0d expected %0d", issue_log.size(), FQ_DEPTH);
    end
    n_checks++;
    if (obs_req_valid !== 1'b0 || obs_id_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_full: got req_valid=%b id_valid=%b expected 0 and 1", obs_req_valid, obs_id_valid);
    end
    id_ready = 1'b1;
    for (int i = 0; i < 30 && xfer_log.size() < FQ_DEPTH + 2; i++) step();
    n_checks++;
    if (xfer_log.size() < FQ_DEPTH + 2) begin
      n_errors++;
      $display("FAIL bp_drain_count: got %0d expected %0d", xfer_log.size(), FQ_DEPTH + 2);
    end else begin
      for (int i = 0; i < FQ_DEPTH + 2; i++) begin
        n_checks++;
        if (xfer_log[i] !== RESET_PC + 32'(4 * i)) begin
          n_errors++;
          $display("FAIL bp_drain_pc[%0d]: got %h expected %h", i, xfer_log[i], RESET_PC + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect_drop();
    cfg_req_rdy_pct = 100; cfg_lat_min = 6; cfg_lat_max = 6;
    do_reset(1);
    id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && issue_log.size() < 2; i++) step();
    n_checks++;
    if (issue_log.size() != 2 || issue_log[0] !== 32'h10 || issue_log[1] !== 32'h14) begin
      n_errors++;
      $display("FAIL rd_inflight: got %0d issues expected 0x10,0x14", issue_log.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 40 && xfer_log.size() < 1; i++) step();
    n_checks++;
    if (xfer_log.size() < 1 || xfer_log[0] !== 32'h200) begin
      n_errors++;
      $display("FAIL rd_first_pc: got %h (n=%0d) expected 00000200", obs_id_pc, xfer_log.size());
    end
  endtask

  task automatic test_redirect_unaligned();
    cfg_req_rdy_pct = 100; cfg_lat_min = 1; cfg_lat_max = 1;
    do_reset(1);
    id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    step();
    n_checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL ru_addr: got v=%b a=%h expected v=1 a=00000100", obs_req_valid, obs_addr);
    end
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (obs_id_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ru_no_xfer: got id_valid=%b expected 0", obs_id_valid);
    end
    xfer_log.delete();
    for (int i = 0; i < 20 && xfer_log.size() < 1; i++) step();
    n_checks++;
    if (xfer_log.size() < 1 || xfer_log[0] !== 32'h300) begin
      n_errors++;
      $display("FAIL ru_first_pc: got n=%0d last=%h expected 00000300", xfer_log.size(), obs_id_pc);
    end
  endtask

  task automatic test_halt();
    int m;
    cfg_req_rdy_pct = 100; cfg_lat_min = 4; cfg_lat_max = 4;
    do_reset(1);
    id_ready = 1'b1;
    for (int i = 0; i < 10 && issue_log.size() < 2; i++) step();
    halt = 1'b1;
    for (int i = 0; i < 12; i++) step();
    n_checks++;
    if (issue_log.size() != 2) begin
      n_errors++;
      $display("FAIL halt_issue_count: got %0d expected 2", issue_log.size());
    end
    n_checks++;
    if (xfer_log.size() != 2 || xfer_log[0] !== RESET_PC || xfer_log[1] !== RESET_PC + 32'd4) begin
      n_errors++;
      $display("FAIL halt_drain: got %0d words expected 2 (0,4)", xfer_log.size());
    end
    halt = 1'b0;
    for (int i = 0; i < 10 && issue_log.size() < 3; i++) step();
    n_checks++;
    if (issue_log.size() < 3 || issue_log[2] !== RESET_PC + 32'd8) begin
      n_errors++;
      $display("FAIL halt_resume: got n=%0d expected addr %h", issue_log.size(), RESET_PC + 32'd8);
    end
    halt = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    m = issue_log.size();
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (issue_log.size() != m) begin
      n_errors++;
      $display("FAIL halt_redirect_hold: got %0d issues expected %0d", issue_log.size(), m);
    end
    halt = 1'b0;
    for (int i = 0; i < 10 && issue_log.size() <= m; i++) step();
    n_checks++;
    if (issue_log.size() <= m || issue_log[m] !== 32'h400) begin
      n_errors++;
      $display("FAIL halt_redirect_resume: got n=%0d expected addr 00000400", issue_log.size());
    end
  endtask

  task automatic test_wrap();
    cfg_req_rdy_pct = 100; cfg_lat_min = 1; cfg_lat_max = 1;
    do_reset(1);
    id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && xfer_log.size() < 3; i++) step();
    n_checks++;
    if (issue_log.size() < 3 || issue_log[2] !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_issue: got n=%0d expected third addr 00000000", issue_log.size());
    end
    n_checks++;
    if (xfer_log.size() < 3 || xfer_log[1] !== 32'hFFFF_FFFC || xfer_log[2] !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_id_pc: got n=%0d expected fffffffc then 00000000", xfer_log.size());
    end
  endtask

  task automatic test_reset_mid();
    cfg_req_rdy_pct = 100; cfg_lat_min = 1; cfg_lat_max = 1;
    do_reset(1);
    id_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    n_checks++;
    if (obs_id_valid !== 1'b1 || obs_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rm_full: got id_valid=%b req_valid=%b expected 1 and 0", obs_id_valid, obs_req_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (obs_id_valid !== 1'b0 || obs_id_instr !== NOP_OP) begin
      n_errors++;
      $display("FAIL rm_id: got v=%b i=%h expected v=0 i=%h", obs_id_valid, obs_id_instr, NOP_OP);
    end
    n_checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL rm_addr: got v=%b a=%h expected v=1 a=%h", obs_req_valid, obs_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    cfg_req_rdy_pct = 60; cfg_lat_min = 1; cfg_lat_max = 4;
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      if ($urandom_range(0, 99) < 3) halt = ~halt;
      rst = ($urandom_range(0, 999) < 3);
      step();
    end
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    n_checks++;
    if (xfer_log.size() < 300) begin
      n_errors++;
      $display("FAIL rand_progress: got %0d transfers expected >= 300", xfer_log.size());
    end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_data = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_unaligned();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
